// File: rtl/adf_multi_prog.sv
// adf_multi_prog: register image for NUM_CH ADF435x-class PLLs and a serial
// programmer that writes any channel subset over a shared D_CLK/D_OUT bus.
// Optional feature macro ADF_LOCK_WAIT_EN: wait for lock detect after each R0 latch.
`timescale 1ns/1ps
module adf_multi_prog #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned NUM_REGS = 6,
    parameter int unsigned CLK_DIV  = 5,
    parameter int unsigned LE_HOLD  = 2,
    parameter int unsigned LOCK_TMO = 50000,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [31:0]       cfg_data,
    input  logic              start,
    input  logic [NUM_CH-1:0] start_mask,
    output logic              busy,
    output logic              done,
    output logic              D_CLK,
    output logic              D_OUT,
    output logic [NUM_CH-1:0] D_LE,
    input  logic [NUM_CH-1:0] lock_det,
    output logic [NUM_CH-1:0] lock_err
);

    localparam int unsigned DIV_W = $clog2(LE_HOLD * CLK_DIV + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SEL, S_LOAD, S_SHIFT_LO, S_SHIFT_HI,
        S_LE_SETUP, S_LE_PULSE, S_NEXT, S_DONE
`ifdef ADF_LOCK_WAIT_EN
        , S_LOCK_WAIT
`endif
    } state_t;

    state_t            state, state_n;
    logic [31:0]       image [NUM_CH][NUM_REGS];
    logic [NUM_CH-1:0] mask_r, mask_n;
    logic [CH_W-1:0]   ch_r, ch_n, sel_ch;
    logic [IDX_W-1:0]  idx_r, idx_n;
    logic [31:0]       shreg, shreg_n;
    logic [4:0]        bit_cnt, bit_cnt_n;
    logic [DIV_W-1:0]  div_cnt, div_n;
    logic              busy_n, done_n, d_clk_n, d_out_n;
    logic [NUM_CH-1:0] d_le_n;

`ifdef ADF_LOCK_WAIT_EN
    localparam int unsigned TMO_W = $clog2(LOCK_TMO + 1);
    logic [TMO_W-1:0]  tmo_cnt, tmo_n;
    logic [NUM_CH-1:0] lock_s1, lock_s2;
    logic [NUM_CH-1:0] lock_err_n;

    // Two-flop synchroniser for the asynchronous MUXOUT lock indicators
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lock_s1 <= '0;
            lock_s2 <= '0;
        end else begin
            lock_s1 <= lock_det;
            lock_s2 <= lock_s1;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = (^lock_det) | (LOCK_TMO == 0);
    assign lock_err    = '0;
`endif

    // Host register-image writes; out-of-range channel/index is dropped
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int c = 0; c < int'(NUM_CH); c++)
                for (int r = 0; r < int'(NUM_REGS); r++)
                    image[c][r] <= '0;
        end else if (cfg_we && (32'(cfg_ch) < NUM_CH) && (32'(cfg_idx) < NUM_REGS)) begin
            image[cfg_ch][cfg_idx] <= cfg_data;
        end
    end

    // Lowest pending channel in the remaining mask
    always_comb begin
        sel_ch = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--)
            if (mask_r[i]) sel_ch = CH_W'(i);
    end

    // State register and registered datapath/outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= S_IDLE;
            mask_r  <= '0;
            ch_r    <= '0;
            idx_r   <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            D_CLK   <= 1'b0;
            D_OUT   <= 1'b0;
            D_LE    <= '0;
`ifdef ADF_LOCK_WAIT_EN
            tmo_cnt  <= '0;
            lock_err <= '0;
`endif
        end else begin
            state   <= state_n;
            mask_r  <= mask_n;
            ch_r    <= ch_n;
            idx_r   <= idx_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            div_cnt <= div_n;
            busy    <= busy_n;
            done    <= done_n;
            D_CLK   <= d_clk_n;
            D_OUT   <= d_out_n;
            D_LE    <= d_le_n;
`ifdef ADF_LOCK_WAIT_EN
            tmo_cnt  <= tmo_n;
            lock_err <= lock_err_n;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        mask_n    = mask_r;
        ch_n      = ch_r;
        idx_n     = idx_r;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        div_n     = div_cnt;
        busy_n    = busy;
        done_n    = 1'b0;
        d_clk_n   = D_CLK;
        d_out_n   = D_OUT;
        d_le_n    = D_LE;
`ifdef ADF_LOCK_WAIT_EN
        tmo_n      = tmo_cnt;
        lock_err_n = lock_err;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    mask_n = start_mask;
`ifdef ADF_LOCK_WAIT_EN
                    lock_err_n = lock_err & ~start_mask;
`endif
                    if (start_mask == '0) begin
                        state_n = S_DONE;
                    end else begin
                        busy_n  = 1'b1;
                        state_n = S_SEL;
                    end
                end
            end
            S_SEL: begin
                ch_n    = sel_ch;
                mask_n  = mask_r & ~(NUM_CH'(1) << sel_ch);
                idx_n   = IDX_W'(NUM_REGS - 1);
                state_n = S_LOAD;
            end
            S_LOAD: begin
                // First data bit is presented together with the shifter load
                shreg_n   = image[ch_r][idx_r];
                d_out_n   = image[ch_r][idx_r][31];
                d_clk_n   = 1'b0;
                bit_cnt_n = '0;
                div_n     = '0;
                state_n   = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                    div_n   = '0;
                    d_clk_n = 1'b1;
                    state_n = S_SHIFT_HI;
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
            S_SHIFT_HI: begin
                if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                    div_n   = '0;
                    d_clk_n = 1'b0;
                    shreg_n = {shreg[30:0], 1'b0};
                    if (bit_cnt == 5'd31) begin
                        d_out_n = 1'b0;
                        state_n = S_LE_SETUP;
                    end else begin
                        d_out_n   = shreg[30];
                        bit_cnt_n = bit_cnt + 1'b1;
                        state_n   = S_SHIFT_LO;
                    end
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
            S_LE_SETUP: begin
                if (div_cnt == DIV_W'(LE_HOLD * CLK_DIV - 1)) begin
                    div_n   = '0;
                    d_le_n  = NUM_CH'(1) << ch_r;
                    state_n = S_LE_PULSE;
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
            S_LE_PULSE: begin
                if (div_cnt == DIV_W'(LE_HOLD * CLK_DIV - 1)) begin
                    div_n   = '0;
                    d_le_n  = '0;
                    state_n = S_NEXT;
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
            S_NEXT: begin
                if (idx_r != '0) begin
                    idx_n   = idx_r - 1'b1;
                    state_n = S_LOAD;
                end else begin
`ifdef ADF_LOCK_WAIT_EN
                    tmo_n   = '0;
                    state_n = S_LOCK_WAIT;
`else
                    state_n = (mask_r != '0) ? S_SEL : S_DONE;
`endif
                end
            end
`ifdef ADF_LOCK_WAIT_EN
            S_LOCK_WAIT: begin
                if (lock_s2[ch_r] || (tmo_cnt == TMO_W'(LOCK_TMO - 1))) begin
                    if (!lock_s2[ch_r]) lock_err_n[ch_r] = 1'b1;
                    state_n = (mask_r != '0) ? S_SEL : S_DONE;
                end else begin
                    tmo_n = tmo_cnt + 1'b1;
                end
            end
`endif
            S_DONE: begin
                busy_n  = 1'b0;
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule
